// File: rtl/score_keeper.sv
// BCD score accumulator: round-robin award arbiter, digit-serial adder, frame-latched display copies.
// Grant acks next cycle, ADD takes DIGITS cycles, CHECK one; requesters hold award_req until acked.
module score_keeper #(
  parameter int DIGITS      = 4,
  parameter int NREQ        = 4,
  parameter int EXTRA_DIGIT = 3
) (
  input  logic                clk,
  input  logic                resetN,
  input  logic [NREQ-1:0]     award_req,
  input  logic [NREQ*8-1:0]   award_pts,
  output logic [NREQ-1:0]     award_ack,
  input  logic                clear,
  input  logic                frame_start,
  output logic [DIGITS*4-1:0] score_digits,
  output logic [DIGITS*4-1:0] hiscore_digits,
  output logic                extra_life,
  output logic                busy
);

  localparam int SW = DIGITS * 4;
  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int XL = EXTRA_DIGIT * 4;

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, CHECK = 2'd2} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            carry_q, carry_d;
  logic [7:0]      pts_q, pts_d;
  logic [SW-1:0]   wk_q, wk_d;
  logic [SW-1:0]   score_q, score_d;
  logic [SW-1:0]   hi_q, hi_d;
  logic [SW-1:0]   sd_q, sd_d;
  logic [SW-1:0]   hd_q, hd_d;
  logic [NREQ-1:0] ack_q, ack_d;
  logic            xl_q, xl_d;

  logic            gnt_vld;
  logic [PW-1:0]   gnt_idx;
  logic [7:0]      gnt_pts;
  logic [NREQ-1:0] gnt_oh;
  logic [3:0]      dig_a, dig_b, dig_s;
  logic [4:0]      dig_sum;
  logic            dig_co;
  logic            last_dig;

  function automatic logic [3:0] clamp9(input logic [3:0] n);
    return (n > 4'd9) ? 4'd9 : n;
  endfunction

  // Scan starts one past the last grant so every requester eventually wins.
  always_comb begin
    int j;
    j       = 0;
    gnt_vld = 1'b0;
    gnt_idx = ptr_q;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr_q) + 1 + k;
      if (j >= NREQ) j = j - NREQ;
      if (!gnt_vld && award_req[PW'(j)]) begin
        gnt_vld = 1'b1;
        gnt_idx = PW'(j);
      end
    end
    gnt_pts = 8'h00;
    gnt_oh  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == PW'(i)) begin
        gnt_pts   = award_pts[i*8 +: 8];
        gnt_oh[i] = gnt_vld;
      end
    end
  end

  always_comb begin
    dig_a = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      if (cnt_q == CW'(d)) dig_a = wk_q[d*4 +: 4];
    end
    if (cnt_q == CW'(0))      dig_b = pts_q[3:0];
    else if (cnt_q == CW'(1)) dig_b = pts_q[7:4];
    else                      dig_b = 4'd0;
    dig_sum  = {1'b0, dig_a} + {1'b0, dig_b} + {4'd0, carry_q};
    dig_co   = (dig_sum > 5'd9);
    dig_s    = dig_co ? 4'(dig_sum - 5'd10) : dig_sum[3:0];
    last_dig = (cnt_q == CW'(DIGITS - 1));
  end

  always_comb begin
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    pts_d   = pts_q;
    wk_d    = wk_q;
    score_d = score_q;
    hi_d    = hi_q;
    ack_d   = '0;
    xl_d    = 1'b0;
    // Display copies take the committed value from before this edge, never a mid-update one.
    sd_d    = frame_start ? score_q : sd_q;
    hd_d    = frame_start ? hi_q    : hd_q;
    if (clear) begin
      wk_d    = '0;
      score_d = '0;
      cnt_d   = '0;
      carry_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (gnt_vld) begin
            ptr_d   = gnt_idx;
            pts_d   = {clamp9(gnt_pts[7:4]), clamp9(gnt_pts[3:0])};
            ack_d   = gnt_oh;
            wk_d    = score_q;
            cnt_d   = '0;
            carry_d = 1'b0;
          end
        end
        ADD: begin
          for (int d = 0; d < DIGITS; d++) begin
            if (cnt_q == CW'(d)) wk_d[d*4 +: 4] = dig_s;
          end
          if (last_dig && dig_co) wk_d = {DIGITS{4'h9}};
          cnt_d   = cnt_q + 1'b1;
          carry_d = dig_co;
        end
        CHECK: begin
          score_d = wk_q;
          if (wk_q > hi_q) hi_d = wk_q;
          xl_d = (wk_q[SW-1:XL] != score_q[SW-1:XL]);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (gnt_vld) state_d = ADD;
        ADD:     if (last_dig) state_d = CHECK;
        CHECK:   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = (state_q != IDLE);
    award_ack      = ack_q;
    extra_life     = xl_q;
    score_digits   = sd_q;
    hiscore_digits = hd_q;
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q <= IDLE;
      ptr_q   <= PW'(NREQ - 1);
      cnt_q   <= '0;
      carry_q <= 1'b0;
      pts_q   <= 8'h00;
      wk_q    <= '0;
      score_q <= '0;
      hi_q    <= '0;
      sd_q    <= '0;
      hd_q    <= '0;
      ack_q   <= '0;
      xl_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      pts_q   <= pts_d;
      wk_q    <= wk_d;
      score_q <= score_d;
      hi_q    <= hi_d;
      sd_q    <= sd_d;
      hd_q    <= hd_d;
      ack_q   <= ack_d;
      xl_q    <= xl_d;
    end
  end

endmodule

// File: tb/tb_score_keeper.sv
// Bench for score_keeper: stimulus pushes expected acks, extra lives and frame snapshots; a monitor pops and compares.
module tb_score_keeper;
  localparam int DIGITS = 4;
  localparam int NREQ   = 4;

  logic                clk;
  logic                resetN;
  logic [NREQ-1:0]     award_req;
  logic [NREQ*8-1:0]   award_pts;
  logic [NREQ-1:0]     award_ack;
  logic                clear;
  logic                frame_start;
  logic [DIGITS*4-1:0] score_digits;
  logic [DIGITS*4-1:0] hiscore_digits;
  logic                extra_life;
  logic                busy;

  score_keeper #(.DIGITS(DIGITS), .NREQ(NREQ), .EXTRA_DIGIT(3)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .award_req      (award_req),
    .award_pts      (award_pts),
    .award_ack      (award_ack),
    .clear          (clear),
    .frame_start    (frame_start),
    .score_digits   (score_digits),
    .hiscore_digits (hiscore_digits),
    .extra_life     (extra_life),
    .busy           (busy)
  );

  typedef struct {
    int idx;
    int cyc;
  } ack_t;

  ack_t        ack_exp[$];
  int          xl_exp[$];
  logic [31:0] fr_exp[$];

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   tmo_cnt = 0;
  int   model_score = 0;
  int   model_hi = 0;
  logic fs_smp = 1'b0;
  logic done = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    fs_smp <= frame_start;
  end

  function automatic logic [15:0] tobcd(input int v);
    logic [15:0] r;
    r[15:12] = 4'((v / 1000) % 10);
    r[11:8]  = 4'((v / 100) % 10);
    r[7:4]   = 4'((v / 10) % 10);
    r[3:0]   = 4'(v % 10);
    return r;
  endfunction

  always @(negedge clk) begin
    ack_t        e;
    int          xc;
    logic [31:0] f;
    if (!resetN) begin
      checks++;
      if (award_ack != '0 || extra_life || busy) begin
        errors++;
        $display("FAIL reset_ctrl got ack=%b xl=%b busy=%b want 0/0/0", award_ack, extra_life, busy);
      end
      checks++;
      if (score_digits != '0 || hiscore_digits != '0) begin
        errors++;
        $display("FAIL reset_scores got %h/%h want 0000/0000", score_digits, hiscore_digits);
      end
    end else begin
      if (award_ack != '0) begin
        checks++;
        if (ack_exp.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected got %b at cyc %0d", award_ack, cyc);
        end else begin
          e = ack_exp.pop_front();
          if (award_ack != (NREQ'(1) << e.idx) || cyc != e.cyc || !busy) begin
            errors++;
            $display("FAIL ack got %b cyc %0d busy %b want %b cyc %0d busy 1",
                     award_ack, cyc, busy, NREQ'(1) << e.idx, e.cyc);
          end
        end
      end
      if (extra_life) begin
        checks++;
        if (xl_exp.size() == 0) begin
          errors++;
          $display("FAIL xl_unexpected at cyc %0d", cyc);
        end else begin
          xc = xl_exp.pop_front();
          if (cyc != xc) begin
            errors++;
            $display("FAIL xl_timing got cyc %0d want cyc %0d", cyc, xc);
          end
        end
      end
      if (fs_smp) begin
        checks++;
        if (fr_exp.size() == 0) begin
          errors++;
          $display("FAIL frame_unexpected got %h/%h", score_digits, hiscore_digits);
        end else begin
          f = fr_exp.pop_front();
          if ({score_digits, hiscore_digits} != f) begin
            errors++;
            $display("FAIL frame score/hi got %h/%h want %h/%h",
                     score_digits, hiscore_digits, f[31:16], f[15:0]);
          end
        end
      end
    end
    if (done) begin
      checks++;
      if (ack_exp.size() != 0) begin
        errors++;
        $display("FAIL ack_missing got 0 acks want %0d more", ack_exp.size());
      end
      checks++;
      if (xl_exp.size() != 0) begin
        errors++;
        $display("FAIL xl_missing got 0 pulses want %0d more", xl_exp.size());
      end
      checks++;
      if (fr_exp.size() != 0) begin
        errors++;
        $display("FAIL frame_missing want %0d more", fr_exp.size());
      end
      checks++;
      if (tmo_cnt != 0) begin
        errors++;
        $display("FAIL timeouts got %0d want 0", tmo_cnt);
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic push_ack(input int idx, input int c);
    ack_t e;
    e.idx = idx;
    e.cyc = c;
    ack_exp.push_back(e);
  endtask

  task automatic model_add(input logic [7:0] pts, input int ack_cyc);
    int lo, hi, v;
    lo = (pts[3:0] > 4'd9) ? 9 : int'(pts[3:0]);
    hi = (pts[7:4] > 4'd9) ? 9 : int'(pts[7:4]);
    v  = model_score + hi * 10 + lo;
    if (v > 9999) v = 9999;
    if (v / 1000 != model_score / 1000) xl_exp.push_back(ack_cyc + DIGITS + 1);
    model_score = v;
    if (v > model_hi) model_hi = v;
  endtask

  task automatic wait_acks(input int n);
    int got;
    got = 0;
    for (int i = 0; i < 200 && got < n; i++) begin
      @(negedge clk);
      if (award_ack != '0) begin
        got++;
        award_req = award_req & ~award_ack;
      end
    end
    if (got < n) tmo_cnt++;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (busy) tmo_cnt++;
  endtask

  task automatic frame();
    @(negedge clk);
    frame_start = 1'b1;
    fr_exp.push_back({tobcd(model_score), tobcd(model_hi)});
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic award(input int idx, input logic [7:0] pts);
    @(negedge clk);
    award_pts[idx*8 +: 8] = pts;
    award_req[idx] = 1'b1;
    push_ack(idx, cyc + 1);
    model_add(pts, cyc + 1);
    wait_acks(1);
    wait_idle();
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    model_score = 0;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 resetN = 1'b0;
    model_score = 0;
    model_hi = 0;
    repeat (3) @(negedge clk);
    resetN = 1'b1;
  endtask

  initial begin
    int c;
    resetN      = 1'b0;
    award_req   = '0;
    award_pts   = '0;
    clear       = 1'b0;
    frame_start = 1'b0;
    repeat (3) @(negedge clk);

    // Single award granted on the first edge after reset release.
    award_pts[7:0] = 8'h25;
    award_req[0]   = 1'b1;
    push_ack(0, cyc + 1);
    model_add(8'h25, cyc + 1);
    resetN = 1'b1;
    wait_acks(1);
    wait_idle();
    frame();

    // Round robin from a fresh reset: 0,1,2,3 spaced DIGITS+2 apart.
    do_reset();
    frame();
    @(negedge clk);
    award_pts = {4{8'h01}};
    award_req = '1;
    c = cyc;
    for (int k = 0; k < NREQ; k++) begin
      push_ack(k, c + 1 + k * (DIGITS + 2));
      model_add(8'h01, c + 1 + k * (DIGITS + 2));
    end
    wait_acks(NREQ);
    wait_idle();
    frame();

    // Carry chain, zero award, clamp, extra life.
    do_clear();
    frame();
    for (int i = 0; i < 10; i++) award(0, (i == 4) ? 8'hAF : 8'h99);
    award(0, 8'h05);
    award(0, 8'h00);
    frame();
    award(0, 8'h10);
    frame();
    award(0, 8'h50);
    frame();

    // Clear in the middle of ADD with req[2] raised alongside the clear.
    @(negedge clk);
    award_pts[15:8] = 8'h50;
    award_req[1]    = 1'b1;
    c = cyc;
    push_ack(1, c + 1);
    @(negedge clk);
    award_req[1]     = 1'b0;
    award_pts[23:16] = 8'h07;
    award_req[2]     = 1'b1;
    clear            = 1'b1;
    model_score      = 0;
    push_ack(2, c + 3);
    @(negedge clk);
    clear       = 1'b0;
    frame_start = 1'b1;
    fr_exp.push_back({tobcd(model_score), tobcd(model_hi)});
    @(negedge clk);
    frame_start  = 1'b0;
    award_req[2] = 1'b0;
    model_add(8'h07, c + 3);
    wait_idle();
    frame();

    // frame_start lands on the CHECK edge: old value this frame, new one next.
    @(negedge clk);
    award_pts[7:0] = 8'h01;
    award_req[0]   = 1'b1;
    c = cyc;
    push_ack(0, c + 1);
    @(negedge clk);
    award_req[0] = 1'b0;
    repeat (DIGITS) @(negedge clk);
    frame_start = 1'b1;
    fr_exp.push_back({tobcd(model_score), tobcd(model_hi)});
    model_add(8'h01, c + 1);
    @(negedge clk);
    frame_start = 1'b0;
    wait_idle();
    frame();

    // Saturation at 9999.
    do_clear();
    for (int i = 0; i < 100; i++) award(0, (i == 50) ? 8'hFA : 8'h99);
    award(0, 8'h90);
    frame();
    award(0, 8'h99);
    frame();
    award(0, 8'h01);
    frame();

    repeat (12) @(negedge clk);
    @(posedge clk);
    done = 1'b1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/score_keeper.md
SCORE_KEEPER -- requirements
Module: score_keeper

Interface
REQ-001 Parameter DIGITS, default 4: number of BCD score digits.
REQ-002 Parameter NREQ, default 4: number of award requesters.
REQ-003 Parameter EXTRA_DIGIT, default 3: digit index whose rollover grants an extra life (every 1000 points at default).
REQ-004 clk  in  1  system clock; all state changes on its rising edge.
REQ-005 resetN  in  1  asynchronous, active-low reset.
REQ-006 award_req  in  NREQ  per-requester award request, level, held until acked.
REQ-007 award_pts  in  NREQ*8  two BCD digits of points per requester; requester i uses bits [8i+7:8i].
REQ-008 award_ack  out  NREQ  one-hot, one-cycle grant/acceptance pulse.
REQ-009 clear  in  1  new-game pulse; zeroes the score.
REQ-010 frame_start  in  1  one-cycle pulse at pixel (0,0) of each frame.
REQ-011 score_digits  out  DIGITS*4  frame-latched BCD score, feeds the score drawing block.
REQ-012 hiscore_digits  out  DIGITS*4  frame-latched BCD high score.
REQ-013 extra_life  out  1  one-cycle pulse on an EXTRA_DIGIT-boundary crossing.
REQ-014 busy  out  1  high whenever the FSM is not IDLE.

Function
REQ-015 The FSM SHALL have states IDLE, ADD and CHECK.
REQ-016 In IDLE, when any award_req is high, the arbiter SHALL grant round-robin, starting at the index after the last grant; the pointer resets to NREQ-1 so requester 0 wins first.
REQ-017 On a grant at edge T, the block SHALL latch the granted award_pts, pulse award_ack[i] during cycle T+1 only, and enter ADD.
REQ-018 ADD SHALL last exactly DIGITS cycles and add one BCD digit per cycle, LSD first, with a carry chain into the working score; award digits above index 1 count as 0.
REQ-019 Any award_pts nibble greater than 9 SHALL be clamped to 9.
REQ-020 If the add carries out of digit DIGITS-1, the working score SHALL saturate to all 9s.
REQ-021 CHECK SHALL last 1 cycle and perform four actions:
  - copy the working score to the committed score;
  - set the committed high score to the new score if the new score is greater (BCD magnitude compare);
  - pulse extra_life if digits [DIGITS-1:EXTRA_DIGIT] of the new score differ from those of the old committed score;
  - return to IDLE.
REQ-022 Grant-to-commit latency SHALL be DIGITS+2 cycles, and a new grant SHALL be possible on the cycle IDLE is re-entered.
REQ-023 A zero-point award SHALL still be acked and sequenced, with no score change and no extra_life.
REQ-024 Requesters not granted SHALL stay pending, with no ack, until they win arbitration.
REQ-025 On frame_start, score_digits and hiscore_digits SHALL load the committed values; mid-update values SHALL never appear.
REQ-026 When frame_start and CHECK occur in the same cycle, the outputs SHALL take the pre-CHECK committed values, and the new values SHALL appear on the next frame_start.
REQ-027 clear SHALL take priority in any state:
  - the next state is IDLE;
  - the working and committed scores go to 0;
  - the high score is kept;
  - no ack and no extra_life are issued in that cycle;
  - an in-flight award is discarded.
REQ-028 When clear and award_req occur in the same cycle, the request SHALL stay pending and SHALL be serviced after the clear.
REQ-029 busy SHALL be high in ADD and CHECK.

Reset
REQ-030 While resetN is low, the block SHALL force:
  - state to IDLE;
  - all scores, high score, score_digits and hiscore_digits to 0;
  - award_ack to 0, extra_life to 0 and busy to 0;
  - the round-robin pointer to NREQ-1.
REQ-031 Deassertion of resetN SHALL need no extra cycles; a request may be granted on the first edge after reset is released.

Verification
REQ-032 The bench SHALL cover a single award: req[0] with pts 8'h25 → ack[0] 1 cycle later; after frame_start, score_digits=16'h0025 and hiscore_digits=16'h0025.
REQ-033 The bench SHALL cover round-robin: all four requesters held with pts 8'h01 → acks in order 0,1,2,3 spaced DIGITS+2 cycles apart; final score 16'h0004.
REQ-034 The bench SHALL cover carry and extra life: score 0995 plus 8'h10 → score 1005, extra_life one pulse; then 8'h50 → 1055, no pulse.
REQ-035 The bench SHALL cover saturation: score 9990 plus 8'h99 → score 9999; then 8'h01 → score stays 9999 with no extra_life.
REQ-036 The bench SHALL cover clear mid-ADD: clear → score 0 on the next frame_start, high score unchanged, pending req[2] acked afterwards.
REQ-037 The bench SHALL cover frame_start coincident with CHECK → score_digits holds the old value for that frame and updates on the next frame_start.
